// File: rtl/d_branch_resolver.sv
// rtl/d_branch_resolver.sv - decode-stage branch/jump resolver with D/E register and perf counters
//
// Purpose: decodes MIPS control transfers in D, evaluates the branch condition
// on forwarded operands, drives the fetch redirect, interlocks on operands that
// are still in flight, and owns the D/E register fields used for the link write.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   d_valid/d_ins/d_pc    F/D register contents
//   rs_val/rt_val         forwarded operands, qualified by rs_ready/rt_ready
//   e_ready               E stage accepts a new instruction this cycle
//   clr_cnt               synchronous clear of the performance counters
//   d_stall               hold PC and F/D
//   redirect/redirect_pc  combinational fetch redirect and target
//   flush_f               squash the fetched instruction (no-delay-slot mode only)
//   e_*                   D/E register: valid, pc, ins, link write, address error
//   cnt_*                 saturating branch / taken / stall counters
module d_branch_resolver #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [31:0]      d_ins,
  input  logic [XLEN-1:0]  d_pc,
  input  logic [XLEN-1:0]  rs_val,
  input  logic [XLEN-1:0]  rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             e_ready,
  input  logic             clr_cnt,
  output logic             d_stall,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_f,
  output logic             e_valid,
  output logic [XLEN-1:0]  e_pc,
  output logic [31:0]      e_ins,
  output logic             e_link_we,
  output logic [4:0]       e_link_reg,
  output logic [XLEN-1:0]  e_link_val,
  output logic             e_adel,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Bits of the PC replaced by a j/jal target; everything above is kept from pc+4.
  localparam logic [XLEN-1:0] LOW28_MASK = XLEN'(28'hFFF_FFFF);
  // With a delay slot the return address skips the slot instruction.
  localparam logic [XLEN-1:0] LINK_OFS   = (DELAY_SLOT != 0) ? XLEN'(8) : XLEN'(4);

  // ---------------------------------------------------------------- decode
  logic [5:0] opcode;
  logic [4:0] rt_f;
  logic [5:0] funct;

  assign opcode = d_ins[31:26];
  assign rt_f   = d_ins[20:16];
  assign funct  = d_ins[5:0];

  logic is_beq, is_bne, is_blez, is_bgtz, is_bltz, is_bgez;
  logic is_j, is_jal, is_jr, is_jalr;

  always_comb begin
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_blez = 1'b0;
    is_bgtz = 1'b0;
    is_bltz = 1'b0;
    is_bgez = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    case (opcode)
      6'b000100: is_beq  = 1'b1;
      6'b000101: is_bne  = 1'b1;
      6'b000110: is_blez = 1'b1;
      6'b000111: is_bgtz = 1'b1;
      6'b000001: begin
        // REGIMM encodings other than bltz/bgez are not control transfers here.
        is_bltz = (rt_f == 5'b00000);
        is_bgez = (rt_f == 5'b00001);
      end
      6'b000010: is_j    = 1'b1;
      6'b000011: is_jal  = 1'b1;
      6'b000000: begin
        is_jr   = (funct == 6'b001000);
        is_jalr = (funct == 6'b001001);
      end
      default: ;
    endcase
  end

  logic is_cond, is_jump, is_reg_jump, need_rs, need_rt, ops_ok;

  assign is_cond     = is_beq | is_bne | is_blez | is_bgtz | is_bltz | is_bgez;
  assign is_reg_jump = is_jr | is_jalr;
  assign is_jump     = is_j | is_jal | is_reg_jump;
  assign need_rs     = is_cond | is_reg_jump;
  assign need_rt     = is_beq | is_bne;
  assign ops_ok      = (~need_rs | rs_ready) & (~need_rt | rt_ready);

  // ------------------------------------------------------------ condition
  // Sign tests reduce to the MSB and a zero test on the full operand width.
  logic rs_eq_rt, rs_zero, rs_neg, cond_taken;

  assign rs_eq_rt = (rs_val == rt_val);
  assign rs_zero  = (rs_val == '0);
  assign rs_neg   = rs_val[XLEN-1];

  always_comb begin
    cond_taken = 1'b0;
    if (is_beq)  cond_taken = rs_eq_rt;
    if (is_bne)  cond_taken = ~rs_eq_rt;
    if (is_blez) cond_taken = rs_neg | rs_zero;
    if (is_bgtz) cond_taken = ~rs_neg & ~rs_zero;
    if (is_bltz) cond_taken = rs_neg;
    if (is_bgez) cond_taken = ~rs_neg;
  end

  // --------------------------------------------------------------- targets
  logic [XLEN-1:0] pc_plus4, imm_sext, br_target, jmp_target;

  assign pc_plus4   = d_pc + XLEN'(4);
  assign imm_sext   = {{(XLEN-16){d_ins[15]}}, d_ins[15:0]};
  assign br_target  = pc_plus4 + (imm_sext << 2);
  assign jmp_target = (pc_plus4 & ~LOW28_MASK) | XLEN'({d_ins[25:0], 2'b00});

  always_comb begin
    redirect_pc = br_target;
    if (is_reg_jump)         redirect_pc = rs_val;
    else if (is_j || is_jal) redirect_pc = jmp_target;
  end

  // ------------------------------------------------------------ handshake
  // Gating with reset keeps every combinational control output low while
  // reset is held, whatever sits in F/D.
  logic fire;

  assign fire = reset & d_valid & ops_ok & e_ready;

  // -------------------------------------------------------------------- FSM
  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    d_stall  = 1'b0;
    redirect = 1'b0;
    flush_f  = 1'b0;
    case (state_q)
      ST_RUN:  if (d_valid && !ops_ok) state_d = ST_WAIT;
      // A squashed F/D (d_valid low) abandons the wait without redirecting.
      ST_WAIT: if (fire || !d_valid) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    d_stall  = reset & d_valid & ~fire;
    // fire is a single cycle per instruction, so the redirect is one pulse
    // however long the instruction waited for its operands.
    redirect = fire & ((is_cond & cond_taken) | is_jump);
    flush_f  = redirect & (DELAY_SLOT == 0);
  end

  // ----------------------------------------------------------- D/E register
  logic            e_valid_q, e_link_we_q, e_adel_q;
  logic [XLEN-1:0] e_pc_q, e_link_val_q;
  logic [31:0]     e_ins_q;
  logic [4:0]      e_link_reg_q;
  logic            link_we_d, adel_d;
  logic [4:0]      link_reg_d;

  assign link_we_d  = is_jal | is_jalr;
  assign link_reg_d = is_jal ? 5'd31 : (is_jalr ? d_ins[15:11] : 5'd0);
  assign adel_d     = is_reg_jump & (rs_val[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid_q    <= 1'b0;
      e_pc_q       <= '0;
      e_ins_q      <= '0;
      e_link_we_q  <= 1'b0;
      e_link_reg_q <= '0;
      e_link_val_q <= '0;
      e_adel_q     <= 1'b0;
    end else if (fire) begin
      e_valid_q    <= 1'b1;
      e_pc_q       <= d_pc;
      e_ins_q      <= d_ins;
      e_link_we_q  <= link_we_d;
      e_link_reg_q <= link_reg_d;
      e_link_val_q <= d_pc + LINK_OFS;
      e_adel_q     <= adel_d;
    end else if (e_ready) begin
      // Bubble: the side-effect qualifiers drop with valid so E never acts on it.
      e_valid_q    <= 1'b0;
      e_link_we_q  <= 1'b0;
      e_adel_q     <= 1'b0;
    end
  end

  assign e_valid    = e_valid_q;
  assign e_pc       = e_pc_q;
  assign e_ins      = e_ins_q;
  assign e_link_we  = e_link_we_q;
  assign e_link_reg = e_link_reg_q;
  assign e_link_val = e_link_val_q;
  assign e_adel     = e_adel_q;

  // ------------------------------------------------------------- counters
  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] q,
                                                input logic             inc,
                                                input logic             clr);
    if (clr)                 return '0;
    else if (inc && ~&q)     return q + CNT_W'(1);
    else                     return q;
  endfunction

  logic [CNT_W-1:0] cnt_branch_q, cnt_taken_q, cnt_stall_q;
  logic [CNT_W-1:0] cnt_branch_d, cnt_taken_d, cnt_stall_d;

  assign cnt_branch_d = sat_next(cnt_branch_q, fire & is_cond, clr_cnt);
  assign cnt_taken_d  = sat_next(cnt_taken_q, fire & is_cond & cond_taken, clr_cnt);
  assign cnt_stall_d  = sat_next(cnt_stall_q, d_stall, clr_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  assign cnt_branch = cnt_branch_q;
  assign cnt_taken  = cnt_taken_q;
  assign cnt_stall  = cnt_stall_q;

endmodule

// File: tb/tb_d_branch_resolver.sv
// tb/tb_d_branch_resolver.sv - self-checking bench for d_branch_resolver
module tb_d_branch_resolver;

  logic        clk = 1'b0;
  logic        reset, d_valid, rs_ready, rt_ready, e_ready, clr_cnt;
  logic [31:0] d_ins, d_pc, rs_val, rt_val;

  // Instance 0: delay slot, 16-bit counters. Instance 1: no delay slot, 2-bit counters.
  wire        o_stall [2];
  wire        o_redir [2];
  wire        o_flush [2];
  wire        o_ev    [2];
  wire        o_lwe   [2];
  wire        o_adel  [2];
  wire [31:0] o_rpc   [2];
  wire [31:0] o_epc   [2];
  wire [31:0] o_eins  [2];
  wire [31:0] o_lval  [2];
  wire [4:0]  o_lreg  [2];
  wire [15:0] o_cb    [2];
  wire [15:0] o_ct    [2];
  wire [15:0] o_cs    [2];
  wire [1:0]  b_cb, b_ct, b_cs;

  assign o_cb[1] = {14'b0, b_cb};
  assign o_ct[1] = {14'b0, b_ct};
  assign o_cs[1] = {14'b0, b_cs};

  d_branch_resolver #(.XLEN(32), .DELAY_SLOT(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ins(d_ins), .d_pc(d_pc),
    .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .e_ready(e_ready), .clr_cnt(clr_cnt),
    .d_stall(o_stall[0]), .redirect(o_redir[0]), .redirect_pc(o_rpc[0]), .flush_f(o_flush[0]),
    .e_valid(o_ev[0]), .e_pc(o_epc[0]), .e_ins(o_eins[0]), .e_link_we(o_lwe[0]),
    .e_link_reg(o_lreg[0]), .e_link_val(o_lval[0]), .e_adel(o_adel[0]),
    .cnt_branch(o_cb[0]), .cnt_taken(o_ct[0]), .cnt_stall(o_cs[0])
  );

  d_branch_resolver #(.XLEN(32), .DELAY_SLOT(0), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ins(d_ins), .d_pc(d_pc),
    .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .e_ready(e_ready), .clr_cnt(clr_cnt),
    .d_stall(o_stall[1]), .redirect(o_redir[1]), .redirect_pc(o_rpc[1]), .flush_f(o_flush[1]),
    .e_valid(o_ev[1]), .e_pc(o_epc[1]), .e_ins(o_eins[1]), .e_link_we(o_lwe[1]),
    .e_link_reg(o_lreg[1]), .e_link_val(o_lval[1]), .e_adel(o_adel[1]),
    .cnt_branch(b_cb), .cnt_taken(b_ct), .cnt_stall(b_cs)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct packed {
    logic        need_rs, need_rt, cond, jump, taken, link, jr;
    logic [4:0]  lreg;
    logic [31:0] tgt;
  } dec_t;

  function automatic dec_t model_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
    dec_t   d;
    longint sa, sb, p, off;
    d   = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = longint'(pc);
    off = longint'($signed(ins[15:0])) * 4;
    case (ins[31:26])
      6'd4: begin d.cond = 1; d.need_rs = 1; d.need_rt = 1; d.taken = (sa == sb); end
      6'd5: begin d.cond = 1; d.need_rs = 1; d.need_rt = 1; d.taken = (sa != sb); end
      6'd6: begin d.cond = 1; d.need_rs = 1; d.taken = (sa <= 0); end
      6'd7: begin d.cond = 1; d.need_rs = 1; d.taken = (sa > 0); end
      6'd1: begin
        if (ins[20:16] == 5'd0) begin d.cond = 1; d.need_rs = 1; d.taken = (sa < 0); end
        if (ins[20:16] == 5'd1) begin d.cond = 1; d.need_rs = 1; d.taken = (sa >= 0); end
      end
      6'd2, 6'd3: begin
        d.jump = 1;
        d.tgt  = 32'((p + 4) - ((p + 4) % (longint'(1) << 28)) + longint'(ins[25:0]) * 4);
        if (ins[31:26] == 6'd3) begin d.link = 1; d.lreg = 5'd31; end
      end
      6'd0: begin
        if (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) begin
          d.need_rs = 1; d.jump = 1; d.jr = 1; d.tgt = a;
          if (ins[5:0] == 6'd9) begin d.link = 1; d.lreg = ins[15:11]; end
        end
      end
      default: ;
    endcase
    if (d.cond) d.tgt = 32'(p + 4 + off);
    return d;
  endfunction

  int          ds   [2] = '{1, 0};
  int          cmax [2] = '{65535, 3};
  bit          m_ev [2], m_lwe [2], m_adel [2];
  logic [31:0] m_epc [2], m_eins [2], m_lval [2];
  logic [4:0]  m_lreg [2];
  int          m_cb [2], m_ct [2], m_cs [2];
  bit          last_fire;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ev[i] = 0; m_lwe[i] = 0; m_adel[i] = 0;
      m_epc[i] = '0; m_eins[i] = '0; m_lval[i] = '0; m_lreg[i] = '0;
      m_cb[i] = 0; m_ct[i] = 0; m_cs[i] = 0;
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst.u%0d.stall", i), o_stall[i], 0);
      chk($sformatf("rst.u%0d.redirect", i), o_redir[i], 0);
      chk($sformatf("rst.u%0d.flush", i), o_flush[i], 0);
      chk($sformatf("rst.u%0d.e_valid", i), o_ev[i], 0);
      chk($sformatf("rst.u%0d.e_pc", i), o_epc[i], 0);
      chk($sformatf("rst.u%0d.e_ins", i), o_eins[i], 0);
      chk($sformatf("rst.u%0d.link_we", i), o_lwe[i], 0);
      chk($sformatf("rst.u%0d.link_reg", i), o_lreg[i], 0);
      chk($sformatf("rst.u%0d.link_val", i), o_lval[i], 0);
      chk($sformatf("rst.u%0d.adel", i), o_adel[i], 0);
      chk($sformatf("rst.u%0d.cnt_branch", i), o_cb[i], 0);
      chk($sformatf("rst.u%0d.cnt_taken", i), o_ct[i], 0);
      chk($sformatf("rst.u%0d.cnt_stall", i), o_cs[i], 0);
    end
  endtask

  // Move to a sampling point half a period away from the rising edge.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Compare every output against the model, then advance the model across the edge.
  task automatic cycle_here();
    dec_t d;
    bit   ok, fire, stall, redir;
    d     = model_dec(d_ins, d_pc, rs_val, rt_val);
    ok    = (!d.need_rs || rs_ready) && (!d.need_rt || rt_ready);
    fire  = reset && d_valid && ok && e_ready;
    stall = reset && d_valid && !fire;
    redir = fire && (d.jump || (d.cond && d.taken));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.stall", i), o_stall[i], stall);
      chk($sformatf("u%0d.redirect", i), o_redir[i], redir);
      chk($sformatf("u%0d.flush", i), o_flush[i], redir && (ds[i] == 0));
      if (redir) chk($sformatf("u%0d.redirect_pc", i), o_rpc[i], d.tgt);
      chk($sformatf("u%0d.e_valid", i), o_ev[i], m_ev[i]);
      if (m_ev[i]) begin
        chk($sformatf("u%0d.e_pc", i), o_epc[i], m_epc[i]);
        chk($sformatf("u%0d.e_ins", i), o_eins[i], m_eins[i]);
        chk($sformatf("u%0d.link_we", i), o_lwe[i], m_lwe[i]);
        chk($sformatf("u%0d.adel", i), o_adel[i], m_adel[i]);
        if (m_lwe[i]) begin
          chk($sformatf("u%0d.link_reg", i), o_lreg[i], m_lreg[i]);
          chk($sformatf("u%0d.link_val", i), o_lval[i], m_lval[i]);
        end
      end
      chk($sformatf("u%0d.cnt_branch", i), o_cb[i], m_cb[i]);
      chk($sformatf("u%0d.cnt_taken", i), o_ct[i], m_ct[i]);
      chk($sformatf("u%0d.cnt_stall", i), o_cs[i], m_cs[i]);
    end
    for (int i = 0; i < 2; i++) begin
      if (fire) begin
        m_ev[i]   = 1;
        m_epc[i]  = d_pc;
        m_eins[i] = d_ins;
        m_lwe[i]  = d.link;
        m_lreg[i] = d.lreg;
        m_lval[i] = d_pc + ((ds[i] != 0) ? 32'd8 : 32'd4);
        m_adel[i] = d.jr && (rs_val % 4 != 0);
      end else if (e_ready) begin
        m_ev[i] = 0; m_lwe[i] = 0; m_adel[i] = 0;
      end
      if (clr_cnt) begin
        m_cb[i] = 0; m_ct[i] = 0; m_cs[i] = 0;
      end else begin
        if (fire && d.cond && m_cb[i] < cmax[i]) m_cb[i]++;
        if (fire && d.cond && d.taken && m_ct[i] < cmax[i]) m_ct[i]++;
        if (stall && m_cs[i] < cmax[i]) m_cs[i]++;
      end
    end
    last_fire = fire;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    cycle_here();
  endtask

  // --------------------------------------------------------- stimulus help
  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rd,
                                       input logic [5:0] fn);
    return {6'd0, rs, 5'd0, rd, 5'd0, fn};
  endfunction

  task automatic put(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] b, input bit ra, input bit rb, input bit er);
    d_valid = 1; d_ins = ins; d_pc = pc; rs_val = a; rt_val = b;
    rs_ready = ra; rt_ready = rb; e_ready = er;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  r5;
    logic [15:0] r16;
    r5  = 5'($urandom);
    r16 = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return mk_i(6'd4, r5, 5'($urandom), r16);
      1:  return mk_i(6'd5, r5, 5'($urandom), r16);
      2:  return mk_i(6'd6, r5, 5'd0, r16);
      3:  return mk_i(6'd7, r5, 5'd0, r16);
      4:  return mk_i(6'd1, r5, 5'd0, r16);
      5:  return mk_i(6'd1, r5, 5'd1, r16);
      6:  return mk_j(6'd2, 26'($urandom));
      7:  return mk_j(6'd3, 26'($urandom));
      8:  return mk_r(r5, 5'($urandom), 6'd8);
      9:  return mk_r(r5, 5'($urandom), 6'd9);
      10: return mk_i(6'd1, r5, 5'($urandom_range(2, 31)), r16);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ------------------------------------------------------------ sequence
  initial begin
    bit have;
    reset = 0; d_valid = 0; d_ins = '0; d_pc = '0; rs_val = '0; rt_val = '0;
    rs_ready = 0; rt_ready = 0; e_ready = 0; clr_cnt = 0;
    model_reset();
    #2 check_reset();
    @(posedge clk); #1;
    put(mk_j(6'd3, 26'h0000C01), 32'h3000, 0, 0, 1, 1, 1);
    #1 check_reset();
    d_valid = 0;
    reset = 1;
    cycle();

    // Taken beq: target 0x3004 + (3 << 2).
    put(mk_i(6'd4, 5'd1, 5'd2, 16'h0003), 32'h3000, 32'd5, 32'd5, 1, 1, 1);
    settle();
    chk("beq.redirect", o_redir[0], 1);
    chk("beq.redirect_pc", o_rpc[0], 32'h3010);
    chk("beq.flush_ds1", o_flush[0], 0);
    cycle_here();
    d_valid = 0;
    settle();
    chk("beq.cnt_taken", o_ct[0], 1);
    cycle_here();

    // bne waits two cycles for rt, then redirects once.
    put(mk_i(6'd5, 5'd1, 5'd2, 16'h0010), 32'h3100, 32'd1, 32'd2, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("bne.wait_stall", o_stall[0], 1);
      chk("bne.wait_redirect", o_redir[0], 0);
      cycle_here();
    end
    rt_ready = 1;
    settle();
    chk("bne.fire_redirect", o_redir[0], 1);
    chk("bne.fire_stall", o_stall[0], 0);
    cycle_here();
    d_valid = 0;
    settle();
    chk("bne.after_redirect", o_redir[0], 0);
    chk("bne.cnt_stall", o_cs[0], 2);
    cycle_here();

    // jal: link value depends on delay-slot mode.
    put(mk_j(6'd3, 26'h0000C01), 32'h3000, 0, 0, 0, 0, 1);
    settle();
    chk("jal.redirect_pc", o_rpc[0], 32'h3004);
    chk("jal.flush_ds1", o_flush[0], 0);
    chk("jal.flush_ds0", o_flush[1], 1);
    cycle_here();
    d_valid = 0;
    settle();
    chk("jal.link_we", o_lwe[0], 1);
    chk("jal.link_reg", o_lreg[0], 31);
    chk("jal.link_val_ds1", o_lval[0], 32'h3008);
    chk("jal.link_val_ds0", o_lval[1], 32'h3004);
    cycle_here();

    // jr held by e_ready, misaligned target raises e_adel.
    put(mk_r(5'd4, 5'd0, 6'd8), 32'h3200, 32'h3002, 0, 1, 0, 0);
    settle();
    chk("jr.hold_stall", o_stall[0], 1);
    chk("jr.hold_redirect", o_redir[0], 0);
    cycle_here();
    e_ready = 1;
    settle();
    chk("jr.redirect", o_redir[0], 1);
    chk("jr.redirect_pc", o_rpc[0], 32'h3002);
    cycle_here();
    d_valid = 0;
    settle();
    chk("jr.adel", o_adel[0], 1);
    cycle_here();

    // bltz / bgez on the most negative value.
    put(mk_i(6'd1, 5'd3, 5'd0, 16'h0010), 32'h3300, 32'h8000_0000, 0, 1, 0, 1);
    settle();
    chk("bltz.redirect", o_redir[0], 1);
    cycle_here();
    put(mk_i(6'd1, 5'd3, 5'd1, 16'h0010), 32'h3304, 32'h8000_0000, 0, 1, 0, 1);
    settle();
    chk("bgez.redirect", o_redir[0], 0);
    cycle_here();
    d_valid = 0;
    settle();
    chk("bgez.cnt_branch", o_cb[0], 4);
    chk("bgez.cnt_taken", o_ct[0], 3);
    chk("bgez.cnt_branch_sat", o_cb[1], 3);
    cycle_here();

    // Five more taken branches: the 2-bit counter stays saturated.
    for (int k = 0; k < 5; k++) begin
      put(mk_i(6'd4, 5'd1, 5'd1, 16'hFFFF), 32'h3400 + 32'(k * 4), 32'd7, 32'd7, 1, 1, 1);
      cycle();
    end
    d_valid = 0;
    settle();
    chk("sat.cnt_taken_w16", o_ct[0], 8);
    chk("sat.cnt_taken_w2", o_ct[1], 3);
    cycle_here();

    // Clear wins over a simultaneous taken fire.
    put(mk_i(6'd4, 5'd1, 5'd1, 16'h0001), 32'h3500, 32'd9, 32'd9, 1, 1, 1);
    clr_cnt = 1;
    cycle();
    clr_cnt = 0;
    d_valid = 0;
    settle();
    chk("clr.cnt_taken_w16", o_ct[0], 0);
    chk("clr.cnt_taken_w2", o_ct[1], 0);
    chk("clr.cnt_branch", o_cb[0], 0);
    cycle_here();

    // F/D squashed while waiting: no redirect.
    put(mk_i(6'd5, 5'd1, 5'd2, 16'h0004), 32'h3600, 32'd1, 32'd2, 1, 0, 1);
    cycle();
    d_valid = 0;
    rt_ready = 1;
    settle();
    chk("squash.redirect", o_redir[0], 0);
    chk("squash.stall", o_stall[0], 0);
    cycle_here();

    // Reset asserted mid-wait clears everything asynchronously.
    put(mk_i(6'd5, 5'd1, 5'd2, 16'h0004), 32'h3700, 32'd1, 32'd2, 1, 0, 1);
    cycle();
    #2 reset = 0;
    #1 check_reset();
    model_reset();
    rt_ready = 1;
    #1 check_reset();
    @(posedge clk); #1;
    check_reset();
    d_valid = 0;
    reset = 1;
    cycle();

    // Randomized traffic: an instruction stays in F/D until it fires or is squashed.
    have = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!have) begin
        d_ins = rand_ins();
        d_pc  = $urandom;
        have  = 1;
      end
      d_valid  = ($urandom_range(0, 9) != 0);
      rs_val   = rand_val();
      rt_val   = ($urandom_range(0, 2) == 0) ? rs_val : rand_val();
      rs_ready = ($urandom_range(0, 3) != 0);
      rt_ready = ($urandom_range(0, 3) != 0);
      e_ready  = ($urandom_range(0, 4) != 0);
      clr_cnt  = ($urandom_range(0, 63) == 0);
      cycle();
      if (last_fire || !d_valid) have = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
